// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM port arbiter: FSM states, grant select, hold default.
// Also carries the tie-break helper so both arbitration builds share one rule.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        ACK  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_VID = 1'b0,
        GNT_CPU = 1'b1
    } gnt_sel_t;

    localparam int HOLD_CYC_DEF = 16;

    // With rr_en low the video port always wins a tie; with rr_en high the
    // port that was not granted last wins.
    function automatic gnt_sel_t arb_pick(input logic     vid_req,
                                          input logic     cpu_req,
                                          input logic     rr_en,
                                          input gnt_sel_t last_gnt);
        if (vid_req && cpu_req) begin
            return (rr_en && (last_gnt == GNT_VID)) ? GNT_CPU : GNT_VID;
        end
        return vid_req ? GNT_VID : GNT_CPU;
    endfunction

endpackage

// File: rtl/rom_hold_timer.sv
// Core hold-off timer: keeps the game core in reset during and after a download.
// Latency: core_hold follows dl_en combinationally, stays high HOLD_CYC cycles after it falls.
// Backpressure: none; also exports the dl_en rising-edge pulse used to clear dl_ovf.
module rom_hold_timer
    import rom_arb_pkg::*;
#(
    parameter int HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_dl_en,
    output logic o_dl_en_rise,
    output logic o_core_hold
);

    localparam logic [7:0] LP_HOLD = 8'(HOLD_CYC);

    logic       r_dl_en_q;
    logic [7:0] r_hold_cnt;

    // The counter is kept loaded for the whole download so the hold window
    // starts in the very cycle dl_en drops, with no one-cycle gap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dl_en_q  <= 1'b0;
            r_hold_cnt <= LP_HOLD;
        end else begin
            r_dl_en_q <= i_dl_en;
            if (i_dl_en) begin
                r_hold_cnt <= LP_HOLD;
            end else if (r_hold_cnt != 8'd0) begin
                r_hold_cnt <= r_hold_cnt - 8'd1;
            end
        end
    end

    assign o_dl_en_rise = i_dl_en & ~r_dl_en_q;
    assign o_core_hold  = i_dl_en | (r_hold_cnt != 8'd0);

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one single-port byte array between HPS download writes, video reads and CPU reads.
// Latency: read ack 3 edges after the IDLE edge that samples req; a pending write issues within 3 cycles.
// Backpressure: req held until ack; dl_en blocks new reads. Macro ROM_ARB_RR_EN selects round-robin ties.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int AW        = 16,
    parameter int ROM_BYTES = 65536,
    parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
    input  logic          clk48M,
    input  logic          reset,
    input  logic          dl_en,
    input  logic          dl_wr,
    input  logic [24:0]   dl_addr,
    input  logic [7:0]    dl_data,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [7:0]    vid_data,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [7:0]    cpu_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          core_hold,
    output logic          dl_ovf
);

    localparam logic [25:0] LP_ROM_LIM = 26'(ROM_BYTES);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    gnt_sel_t      r_gnt;
    gnt_sel_t      w_gnt_sel;

    logic          w_dl_in_range;
    logic          w_dl_en_rise;
    logic          w_rd_ok;
    logic          w_grant;
    logic          w_issue_wr;
    logic          w_capture;

    logic          r_pend_vld;
    logic [AW-1:0] r_pend_addr;
    logic [7:0]    r_pend_data;

    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [7:0]    r_mem_wdata;
    logic [7:0]    r_vid_data;
    logic [7:0]    r_cpu_data;
    logic          r_dl_ovf;

    assign w_dl_in_range = ({1'b0, dl_addr} < LP_ROM_LIM);
    assign w_rd_ok       = ~r_pend_vld & ~dl_en & (vid_req | cpu_req);

`ifdef ROM_ARB_RR_EN
    gnt_sel_t r_last_gnt;

    always_ff @(posedge clk48M) begin
        if (reset) begin
            r_last_gnt <= GNT_CPU;
        end else if (w_grant) begin
            r_last_gnt <= w_gnt_sel;
        end
    end

    assign w_gnt_sel = arb_pick(vid_req, cpu_req, 1'b1, r_last_gnt);
`else
    assign w_gnt_sel = arb_pick(vid_req, cpu_req, 1'b0, GNT_CPU);
`endif

    always_ff @(posedge clk48M) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_rd_ok) w_state_nxt = RD1;
            RD1:     w_state_nxt = RD2;
            RD2:     w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The read address is no longer needed once ACK is reached, so a write
    // that arrived mid-read may already be issued from ACK.
    always_comb begin
        w_issue_wr = 1'b0;
        w_grant    = 1'b0;
        w_capture  = 1'b0;
        vid_ack    = 1'b0;
        cpu_ack    = 1'b0;
        case (r_state)
            IDLE: begin
                w_issue_wr = r_pend_vld;
                w_grant    = w_rd_ok;
            end
            RD2: begin
                w_capture = 1'b1;
            end
            ACK: begin
                w_issue_wr = r_pend_vld;
                vid_ack    = (r_gnt == GNT_VID);
                cpu_ack    = (r_gnt == GNT_CPU);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk48M) begin
        if (reset) begin
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= 8'd0;
        end else if (dl_wr && w_dl_in_range) begin
            r_pend_vld  <= 1'b1;
            r_pend_addr <= dl_addr[AW-1:0];
            r_pend_data <= dl_data;
        end else if (w_issue_wr) begin
            r_pend_vld <= 1'b0;
        end
    end

    // A strobe replacing a write that is not leaving this cycle is a lost byte.
    always_ff @(posedge clk48M) begin
        if (reset) begin
            r_dl_ovf <= 1'b0;
        end else if (dl_wr && (!w_dl_in_range || (r_pend_vld && !w_issue_wr))) begin
            r_dl_ovf <= 1'b1;
        end else if (w_dl_en_rise) begin
            r_dl_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk48M) begin
        if (reset) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
        end else begin
            r_mem_we <= w_issue_wr;
            if (w_issue_wr) begin
                r_mem_addr  <= r_pend_addr;
                r_mem_wdata <= r_pend_data;
            end else if (w_grant) begin
                r_mem_addr <= (w_gnt_sel == GNT_VID) ? vid_addr : cpu_addr;
            end
        end
    end

    always_ff @(posedge clk48M) begin
        if (reset) begin
            r_gnt <= GNT_VID;
        end else if (w_grant) begin
            r_gnt <= w_gnt_sel;
        end
    end

    always_ff @(posedge clk48M) begin
        if (reset) begin
            r_vid_data <= 8'd0;
            r_cpu_data <= 8'd0;
        end else if (w_capture) begin
            if (r_gnt == GNT_VID) begin
                r_vid_data <= mem_rdata;
            end else begin
                r_cpu_data <= mem_rdata;
            end
        end
    end

    rom_hold_timer #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold (
        .i_clk        (clk48M),
        .i_reset      (reset),
        .i_dl_en      (dl_en),
        .o_dl_en_rise (w_dl_en_rise),
        .o_core_hold  (core_hold)
    );

    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign vid_data  = r_vid_data;
    assign cpu_data  = r_cpu_data;
    assign dl_ovf    = r_dl_ovf;

endmodule
